cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that picks one finished reservation
// station per cycle, grants it retirement and drives the common data bus.
// Grant, retire and broadcast are combinational from ready; only the
// rotation pointer (and optional counters) are registered.
// Optional feature macro: CDB_PERF_COUNTERS_EN adds the grant_count and
// contention_count ports and their saturating counters.
module cdb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RS     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RS-1:0]            ready,
    input  logic [NUM_RS-1:0]            has_rd,
    input  logic [NUM_RS*DATA_WIDTH-1:0] result,
    input  logic                         flush,
    output logic [NUM_RS-1:0]            do_retire,
    output logic                         cdb_valid,
    output logic [DATA_WIDTH-1:0]        cdb_result,
    output logic [2:0]                   cdb_rs_id
`ifdef CDB_PERF_COUNTERS_EN
    ,
    output logic [31:0]                  grant_count,
    output logic [31:0]                  contention_count
`endif
);

    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [2:0] grant_idx;
    logic       grant_found;
    logic       grant;
    logic [3:0] idx;
    logic [3:0] g_plus;

    // Search ready starting at ptr and wrapping; first hit wins.
    // idx is kept 4 bits wide so ptr+k never overflows before the modulo fold.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        idx         = 4'd0;
        for (int k = 0; k < NUM_RS; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NUM_RS)) begin
                idx = idx - 4'(NUM_RS);
            end
            for (int i = 0; i < NUM_RS; i++) begin
                if (!grant_found && ready[i] && (idx == 4'(i))) begin
                    grant_found = 1'b1;
                    grant_idx   = 3'(i);
                end
            end
        end
        grant = grant_found && !flush;
    end

    // Retire grant and bus drive; bus fields are zero whenever nothing is broadcast.
    always_comb begin
        do_retire  = '0;
        cdb_valid  = 1'b0;
        cdb_result = '0;
        cdb_rs_id  = 3'd0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (grant && (grant_idx == 3'(i))) begin
                do_retire[i] = 1'b1;
                cdb_valid    = has_rd[i];
                if (has_rd[i]) begin
                    cdb_result = result[i*DATA_WIDTH +: DATA_WIDTH];
                    cdb_rs_id  = 3'(i);
                end
            end
        end
    end

    // Pointer moves just past the winner; holds when no grant (including flush).
    always_comb begin
        g_plus   = {1'b0, grant_idx} + 4'd1;
        ptr_next = ptr;
        if (grant) begin
            ptr_next = (g_plus >= 4'(NUM_RS)) ? 3'd0 : g_plus[2:0];
        end
    end

    // Pointer register; reset drops rotation history so the lowest index is favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 3'd0;
        end else begin
            ptr <= ptr_next;
        end
    end

`ifdef CDB_PERF_COUNTERS_EN
    logic [3:0] ready_cnt;
    logic       contention;

    // Contention means more than one station competing in a non-flush cycle.
    always_comb begin
        ready_cnt = 4'd0;
        for (int i = 0; i < NUM_RS; i++) begin
            ready_cnt = ready_cnt + 4'(ready[i]);
        end
        contention = (ready_cnt > 4'd1) && !flush;
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_count      <= 32'd0;
            contention_count <= 32'd0;
        end else begin
            if (grant && (grant_count != 32'hFFFF_FFFF)) begin
                grant_count <= grant_count + 32'd1;
            end
            if (contention && (contention_count != 32'hFFFF_FFFF)) begin
                contention_count <= contention_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios plus a randomized run
// compared against a behavioural round-robin model.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ready;
    logic [N-1:0]    has_rd;
    logic [N*DW-1:0] result;
    logic            flush;
    logic [N-1:0]    do_retire;
    logic            cdb_valid;
    logic [DW-1:0]   cdb_result;
    logic [2:0]      cdb_rs_id;
`ifdef CDB_PERF_COUNTERS_EN
    logic [31:0]     grant_count;
    logic [31:0]     contention_count;
`endif

    int     tests_run    = 0;
    int     tests_failed = 0;
    int     m_ptr        = 0;
    longint m_gc         = 0;
    longint m_cc         = 0;

    always #5 clk = ~clk;

    cdb_arbiter #(.DATA_WIDTH(DW), .NUM_RS(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready      (ready),
        .has_rd     (has_rd),
        .result     (result),
        .flush      (flush),
        .do_retire  (do_retire),
        .cdb_valid  (cdb_valid),
        .cdb_result (cdb_result),
        .cdb_rs_id  (cdb_rs_id)
`ifdef CDB_PERF_COUNTERS_EN
        ,
        .grant_count      (grant_count),
        .contention_count (contention_count)
`endif
    );

    // Reference: first ready station at or after p, wrapping; -1 if none or flushed.
    function automatic int model_grant(int p, logic [N-1:0] r, logic f);
        int j;
        if (f) return -1;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (((r >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    function automatic int popcount(logic [N-1:0] r);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'((r >> i) & 1);
        return c;
    endfunction

    // Advance one clock edge and update the reference state from the inputs applied.
    task automatic tick();
        int g;
        g = model_grant(m_ptr, ready, flush);
        @(posedge clk);
        if (rst) begin
            m_ptr = 0;
            m_gc  = 0;
            m_cc  = 0;
        end else begin
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                m_gc++;
            end
            if (popcount(ready) > 1 && !flush) m_cc++;
        end
        #1;
    endtask

    task automatic new_results();
        for (int i = 0; i < N; i++) result[i*DW +: DW] = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1; ready = '0; flush = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = '0; has_rd = '0; flush = 1'b0; result = '0;
        tick();
        tick();
        rst = 1'b0;
        #2;
        tests_run++;
        if (do_retire !== 4'b0000) begin tests_failed++; $display("FAIL reset_retire got=%b exp=%b", do_retire, 4'b0000); end
        tests_run++;
        if (cdb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", cdb_valid); end
        tests_run++;
        if (cdb_result !== 32'd0) begin tests_failed++; $display("FAIL reset_result got=%h exp=0", cdb_result); end
        tests_run++;
        if (cdb_rs_id !== 3'd0) begin tests_failed++; $display("FAIL reset_rs_id got=%0d exp=0", cdb_rs_id); end
`ifdef CDB_PERF_COUNTERS_EN
        tests_run++;
        if (grant_count !== 32'd0 || contention_count !== 32'd0) begin
            tests_failed++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", grant_count, contention_count);
        end
`endif
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_r;
        do_reset();
        new_results();
        ready = 4'b1010; has_rd = 4'b1111; flush = 1'b0;
        #2;
        exp_r = result[1*DW +: DW];
        tests_run++;
        if (do_retire !== 4'b0010 || cdb_rs_id !== 3'd1 || cdb_valid !== 1'b1 || cdb_result !== exp_r) begin
            tests_failed++;
            $display("FAIL basic_c0 got=%b/%0d/%b/%h exp=0010/1/1/%h", do_retire, cdb_rs_id, cdb_valid, cdb_result, exp_r);
        end
        tick();
        ready = 4'b1000;
        #2;
        exp_r = result[3*DW +: DW];
        tests_run++;
        if (do_retire !== 4'b1000 || cdb_rs_id !== 3'd3 || cdb_result !== exp_r) begin
            tests_failed++;
            $display("FAIL basic_c1 got=%b/%0d/%h exp=1000/3/%h", do_retire, cdb_rs_id, cdb_result, exp_r);
        end
        tick();
        ready = 4'b1111;
        #2;
        tests_run++;
        if (do_retire !== 4'b0001) begin tests_failed++; $display("FAIL basic_ptr_wrap got=%b exp=0001", do_retire); end
        tick();
    endtask

    task automatic test_rotate();
        logic [N-1:0] exp_d;
        do_reset();
        new_results();
        ready = 4'b1111; has_rd = 4'b1111; flush = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #2;
            exp_d = 4'b0001 << (c % N);
            tests_run++;
            if (do_retire !== exp_d || cdb_rs_id !== 3'(c % N)) begin
                tests_failed++;
                $display("FAIL rotate_c%0d got=%b/%0d exp=%b/%0d", c, do_retire, cdb_rs_id, exp_d, c % N);
            end
            tick();
        end
        ready = '0;
`ifdef CDB_PERF_COUNTERS_EN
        #2;
        tests_run++;
        if (contention_count !== 32'd8 || grant_count !== 32'd8) begin
            tests_failed++; $display("FAIL rotate_counters got=%0d/%0d exp=8/8", contention_count, grant_count);
        end
`endif
    endtask

    task automatic test_no_rd();
        new_results();
        result[2*DW +: DW] = 32'hDEADBEEF;
        ready = 4'b0100; has_rd = 4'b0000; flush = 1'b0;
        #2;
        tests_run++;
        if (do_retire !== 4'b0100 || cdb_valid !== 1'b0 || cdb_result !== 32'd0 || cdb_rs_id !== 3'd0) begin
            tests_failed++;
            $display("FAIL no_rd got=%b/%b/%h/%0d exp=0100/0/0/0", do_retire, cdb_valid, cdb_result, cdb_rs_id);
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        new_results();
        ready = 4'b0010; has_rd = 4'b1111; flush = 1'b0;
        tick();
        ready = 4'b0110; flush = 1'b1;
        #2;
        tests_run++;
        if (do_retire !== 4'b0000 || cdb_valid !== 1'b0 || cdb_result !== 32'd0) begin
            tests_failed++; $display("FAIL flush_suppress got=%b/%b/%h exp=0000/0/0", do_retire, cdb_valid, cdb_result);
        end
        tick();
        flush = 1'b0;
        #2;
        tests_run++;
        if (do_retire !== 4'b0100 || cdb_rs_id !== 3'd2) begin
            tests_failed++; $display("FAIL flush_hold_ptr got=%b/%0d exp=0100/2", do_retire, cdb_rs_id);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        new_results();
        ready = 4'b0100; has_rd = 4'b1111; flush = 1'b0;
        tick();
        ready = 4'b0011; rst = 1'b1;
        #2;
        tests_run++;
        if (do_retire !== 4'b0001 || cdb_rs_id !== 3'd0 || cdb_valid !== 1'b1) begin
            tests_failed++; $display("FAIL reset_mid_same got=%b/%0d/%b exp=0001/0/1", do_retire, cdb_rs_id, cdb_valid);
        end
        tick();
        rst = 1'b0;
        #2;
        tests_run++;
        if (do_retire !== 4'b0001) begin tests_failed++; $display("FAIL reset_mid_after got=%b exp=0001", do_retire); end
        tick();
    endtask

    task automatic test_random();
        int g;
        int wait_cnt [N];
        logic [N-1:0]  exp_d;
        logic          exp_v;
        logic [DW-1:0] exp_r;
        logic [2:0]    exp_id;
        do_reset();
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            ready  = N'($urandom | $urandom);
            if ($urandom_range(0, 5) == 0) ready = N'($urandom);
            has_rd = N'($urandom);
            flush  = ($urandom_range(0, 7) == 0);
            new_results();
            #2;
            g = model_grant(m_ptr, ready, flush);
            exp_d = '0; exp_v = 1'b0; exp_r = '0; exp_id = 3'd0;
            if (g >= 0) begin
                exp_d = N'(1) << g;
                exp_v = ((has_rd >> g) & 1) != 0;
                if (exp_v) begin
                    exp_r  = result[g*DW +: DW];
                    exp_id = 3'(g);
                end
            end
            tests_run++;
            if ({do_retire, cdb_valid, cdb_rs_id, cdb_result} !== {exp_d, exp_v, exp_id, exp_r}) begin
                tests_failed++;
                $display("FAIL random_c%0d got=%b/%b/%0d/%h exp=%b/%b/%0d/%h", c,
                         do_retire, cdb_valid, cdb_rs_id, cdb_result, exp_d, exp_v, exp_id, exp_r);
            end
            tests_run++;
            if ($countones(do_retire) > 1) begin
                tests_failed++; $display("FAIL random_onehot_c%0d got=%b exp=onehot_or_zero", c, do_retire);
            end
            if (!flush) begin
                for (int i = 0; i < N; i++) begin
                    if (((ready >> i) & 1) != 0 && ((do_retire >> i) & 1) == 0) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (((ready >> i) & 1) == 0) wait_cnt[i] = 0;
            end
            tests_run++;
            for (int i = 0; i < N; i++) begin
                if (wait_cnt[i] >= N) begin
                    tests_failed++;
                    $display("FAIL random_starve_c%0d station=%0d waited=%0d limit=%0d", c, i, wait_cnt[i], N - 1);
                    wait_cnt[i] = 0;
                end
            end
            tick();
        end
        ready = '0; flush = 1'b0;
`ifdef CDB_PERF_COUNTERS_EN
        #2;
        tests_run++;
        if (grant_count !== 32'(m_gc) || contention_count !== 32'(m_cc)) begin
            tests_failed++;
            $display("FAIL random_counters got=%0d/%0d exp=%0d/%0d", grant_count, contention_count, m_gc, m_cc);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotate();
        test_no_rd();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
